// File: rtl/disp_pkg.sv
// Shared definitions for the 8-digit display scan path.
//   DEC_EN_ON / DEC_EN_OFF : {e1_low,e2_low,e3} codes that enable/disable decoder3_8
//   NUM_DIGITS, SEL_W      : digit count and select-code width
//   Helper functions for the digit search and nibble extraction used by the scanner.
package disp_pkg;

    localparam logic [2:0] DEC_EN_ON  = 3'b001;
    localparam logic [2:0] DEC_EN_OFF = 3'b110;
    localparam int         NUM_DIGITS = 8;
    localparam int         SEL_W      = 3;
    localparam int         DATA_W     = NUM_DIGITS * 4;

    // Returns {found, index} of the lowest set mask bit strictly above cur.
    function automatic logic [SEL_W:0] next_set_idx(
        input logic [NUM_DIGITS-1:0] m,
        input logic [SEL_W-1:0]      cur
    );
        logic [SEL_W:0] res;
        res = '0;
        // Walk downward so the lowest qualifying index is the one that sticks.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if ((i > int'(cur)) && m[i]) begin
                res = {1'b1, SEL_W'(i)};
            end
        end
        return res;
    endfunction

    // Lowest set index of the mask; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_set_idx(
        input logic [NUM_DIGITS-1:0] m
    );
        logic [SEL_W-1:0] res;
        res = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (m[i]) begin
                res = SEL_W'(i);
            end
        end
        return res;
    endfunction

    // Nibble idx of the packed digit word.
    function automatic logic [3:0] nibble_at(
        input logic [DATA_W-1:0] d,
        input logic [SEL_W-1:0]  idx
    );
        return d[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (counter -> 0)
//   en   : count enable; when low the counter holds
//   tick : high in the cycle the counter sits at CLK_DIV-1 with en=1 (wrap cycle)
module scan_prescaler #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = en && (cnt_r == LAST_CNT);

    // Slot counter: 0..CLK_DIV-1 while enabled, frozen otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scan sequencer feeding decoder3_8 in the 8-digit display path.
//   clk, rst          : system clock / synchronous active-high reset
//   en                : scan enable; low freezes the scan and disables the decoder
//   data[31:0]        : eight nibbles, digit k = data[4k+3:4k]
//   mask[7:0]         : digit k is scanned when mask[k]=1
//   c1,c2,c3          : decoder select, c1 = MSB
//   e1_low,e2_low,e3  : decoder enables
//   hex[3:0]          : nibble of the selected digit, coherent with the select code
//   frame_done        : one-cycle pulse when a frame wraps
// data/mask are only sampled at frame boundaries, so a frame never mixes two images.
module digit_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  mask,
    output logic        c1,
    output logic        c2,
    output logic        c3,
    output logic        e1_low,
    output logic        e2_low,
    output logic        e3,
    output logic [3:0]  hex,
    output logic        frame_done
);

    logic                  tick_s;
    logic                  init_r;
    logic [SEL_W-1:0]      sel_r,         sel_nxt_s;
    logic [3:0]            hex_r,         hex_nxt_s;
    logic [DATA_W-1:0]     shadow_data_r, shadow_data_nxt_s;
    logic [NUM_DIGITS-1:0] shadow_mask_r, shadow_mask_nxt_s;
    logic [2:0]            dec_en_r,      dec_en_nxt_s;
    logic                  frame_done_r,  frame_done_nxt_s;
    logic [SEL_W:0]        next_hit_s;

    scan_prescaler #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick_s)
    );

    // Next-state logic: frame start/wrap reloads the shadows, a plain tick steps to the next digit.
    always_comb begin
        sel_nxt_s         = sel_r;
        hex_nxt_s         = hex_r;
        shadow_data_nxt_s = shadow_data_r;
        shadow_mask_nxt_s = shadow_mask_r;
        frame_done_nxt_s  = 1'b0;
        next_hit_s        = next_set_idx(shadow_mask_r, sel_r);

        // Enables follow the current shadow mask, so they lag a reload by one cycle.
        if (en && (shadow_mask_r != 8'h00)) begin
            dec_en_nxt_s = DEC_EN_ON;
        end else begin
            dec_en_nxt_s = DEC_EN_OFF;
        end

        // init_r marks the first cycle out of reset, which always opens a frame.
        // An empty shadow mask never finds a next digit, so each tick wraps.
        if (init_r || (tick_s && !next_hit_s[SEL_W])) begin
            shadow_data_nxt_s = data;
            shadow_mask_nxt_s = mask;
            sel_nxt_s         = lowest_set_idx(mask);
            hex_nxt_s         = nibble_at(data, lowest_set_idx(mask));
            frame_done_nxt_s  = tick_s;
        end else if (tick_s) begin
            sel_nxt_s = next_hit_s[SEL_W-1:0];
            hex_nxt_s = nibble_at(shadow_data_r, next_hit_s[SEL_W-1:0]);
        end else begin
            sel_nxt_s = sel_r;
            hex_nxt_s = hex_r;
        end
    end

    // State and output registers; reset aborts any slot in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_r        <= 1'b1;
            sel_r         <= 3'b000;
            hex_r         <= 4'h0;
            shadow_data_r <= 32'h0000_0000;
            shadow_mask_r <= 8'h00;
            dec_en_r      <= DEC_EN_OFF;
            frame_done_r  <= 1'b0;
        end else begin
            init_r        <= 1'b0;
            sel_r         <= sel_nxt_s;
            hex_r         <= hex_nxt_s;
            shadow_data_r <= shadow_data_nxt_s;
            shadow_mask_r <= shadow_mask_nxt_s;
            dec_en_r      <= dec_en_nxt_s;
            frame_done_r  <= frame_done_nxt_s;
        end
    end

    assign {c1, c2, c3}         = sel_r;
    assign {e1_low, e2_low, e3} = dec_en_r;
    assign hex                  = hex_r;
    assign frame_done           = frame_done_r;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
module tb_digit_scan_ctrl;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] data;
    logic [7:0]  mask;
    logic        c1, c2, c3, e1_low, e2_low, e3, frame_done;
    logic [3:0]  hex;

    int total = 0;
    int bad   = 0;

    // Reference model state: frame = ordered list of enabled digits plus a slot phase.
    int          m_phase;
    int          m_pos;
    int          m_digits[$];
    logic [31:0] m_data;
    logic [7:0]  m_mask;
    logic [2:0]  m_sel;
    logic [3:0]  m_hex;
    logic        m_done;
    logic [2:0]  m_enab;
    bit          m_init;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .data(data), .mask(mask),
        .c1(c1), .c2(c2), .c3(c3), .e1_low(e1_low), .e2_low(e2_low), .e3(e3),
        .hex(hex), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reload();
        m_data = data;
        m_mask = mask;
        m_digits.delete();
        for (int i = 0; i < 8; i++) if (mask[i]) m_digits.push_back(i);
        m_pos = 0;
        m_sel = (m_digits.size() > 0) ? 3'(m_digits[0]) : 3'd0;
        m_hex = 4'((m_data >> (4 * m_sel)) & 32'hF);
    endtask

    task automatic model_update();
        bit tick;
        if (rst) begin
            m_phase = 0; m_sel = 3'd0; m_hex = 4'h0; m_done = 1'b0;
            m_enab = 3'b110; m_data = 32'h0; m_mask = 8'h0;
            m_digits.delete(); m_pos = 0; m_init = 1'b1;
        end else begin
            m_enab = (en && m_mask != 8'h0) ? 3'b001 : 3'b110;
            m_done = 1'b0;
            tick = en && (m_phase == CLK_DIV - 1);
            if (en) m_phase = (m_phase + 1) % CLK_DIV;
            if (m_init) begin
                model_reload();
                m_init = 1'b0;
            end else if (tick) begin
                m_pos++;
                if (m_pos >= m_digits.size()) begin
                    model_reload();
                    m_done = 1'b1;
                end else begin
                    m_sel = 3'(m_digits[m_pos]);
                    m_hex = 4'((m_data >> (4 * m_sel)) & 32'hF);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] dec_obs, dec_exp;
        dec_obs = ({e1_low, e2_low, e3} == 3'b001) ? (8'h01 << {c1, c2, c3}) : 8'h00;
        dec_exp = (m_enab == 3'b001) ? (8'h01 << m_sel) : 8'h00;
        check("sel", {29'd0, c1, c2, c3}, {29'd0, m_sel});
        check("hex", {28'd0, hex}, {28'd0, m_hex});
        check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
        check("enables", {29'd0, e1_low, e2_low, e3}, {29'd0, m_enab});
        check("decoder", {24'd0, dec_obs}, {24'd0, dec_exp});
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    // Waits (bounded) for one frame_done, then counts cycles to the next one.
    task automatic measure_frame(input string tag, input int exp_len);
        int n;
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        if (seen) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                step();
                n++;
                if (frame_done) seen = 1'b1;
            end
        end
        check(tag, n, exp_len);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
    endtask

    initial begin
        bit         seen;
        logic [2:0] sel_hold;

        // 1. reset, full mask, ascending digits
        rst = 1'b1; en = 1'b1; mask = 8'hFF; data = 32'h7654_3210;
        step(); step();
        check("reset_sel", {29'd0, c1, c2, c3}, 32'd0);
        check("reset_en", {29'd0, e1_low, e2_low, e3}, 32'd6);
        rst = 1'b0;
        measure_frame("frame_len_ff", 32);

        // 2. sparse mask 0,2,7
        mask = 8'b1000_0101;
        measure_frame("frame_len_85", 12);

        // 3. data change mid-frame only shows after the wrap
        step(); step(); step();
        data = 32'hFFFF_FFFF;
        wait_done(seen);
        check("wrap_seen_3", {31'd0, seen}, 32'd1);
        check("hex_new_frame", {28'd0, hex}, 32'hF);

        // 4. freeze mid-slot for 10 cycles
        step(); step();
        en = 1'b0;
        step();
        check("freeze_en_off", {29'd0, e1_low, e2_low, e3}, 32'd6);
        sel_hold = {c1, c2, c3};
        for (int i = 0; i < 9; i++) step();
        check("freeze_sel", {29'd0, c1, c2, c3}, {29'd0, sel_hold});
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // 5. empty mask, then a single digit
        mask = 8'h00;
        measure_frame("frame_len_0", 4);
        check("mask0_sel", {29'd0, c1, c2, c3}, 32'd0);
        check("mask0_en", {29'd0, e1_low, e2_low, e3}, 32'd6);
        mask = 8'h10;
        wait_done(seen);
        check("wrap_seen_5", {31'd0, seen}, 32'd1);
        check("mask10_sel", {29'd0, c1, c2, c3}, 32'd4);
        step();
        check("mask10_en", {29'd0, e1_low, e2_low, e3}, 32'd1);

        // 6. reset during slot 5
        mask = 8'hFF; data = 32'h7654_3210;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if ({c1, c2, c3} == 3'd5) seen = 1'b1;
        end
        check("reach_slot5", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        step();
        check("rst5_sel", {29'd0, c1, c2, c3}, 32'd0);
        check("rst5_en", {29'd0, e1_low, e2_low, e3}, 32'd6);
        check("rst5_hex", {28'd0, hex}, 32'd0);
        check("rst5_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7, 0) == 0) data = $urandom;
            if ($urandom_range(15, 0) == 0) mask = 8'($urandom);
            en  = ($urandom_range(9, 0) != 0);
            rst = ($urandom_range(99, 0) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
